regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port integer register file with per-register scoreboard.
//  It supports NWR write ports and NRD read ports, with optional write-to-read bypass.
//  On reset it runs a sequential zero-init sweep. Busy bits track in-flight producers for hazard checks.
//  Used by the issue/writeback stages of multi-issue core variants.
// PARAMETERS
//  XLEN    32  data width per register
//  NREGS   32  number of architectural registers (power of 2, >=4); AW=$clog2(NREGS)
//  NRD     2   read port count
//  NWR     1   write port count
//  BYPASS  1   1: same-cycle committing write forwarded to reads; 0: reads see stored value
// PORTS
//  clk_i       in   1         clock, all state on rising edge
//  rst_i       in   1         asynchronous reset, active-high
//  stall_i     in   1         1: block all writes, reserves and flushes this cycle
//  ready_o     out  1         1: init sweep done, block accepts traffic
//  we_i        in   NWR       write enable per write port
//  waddr_i     in   NWR*AW    write address, port k at [k*AW +: AW]
//  wdata_i     in   NWR*XLEN  write data, port k at [k*XLEN +: XLEN]
//  raddr_i     in   NRD*AW    read address, port j at [j*AW +: AW]
//  rdata_o     out  NRD*XLEN  read data (combinational)
//  rbusy_o     out  NRD       1: register on port j has a pending producer
//  rsv_i       in   1         reserve request: mark rsv_addr_i busy
//  rsv_addr_i  in   AW        register to reserve
//  flush_i     in   1         clear all busy bits (pipeline flush)
// BEHAVIOUR
//  - Reset (async, rst_i=1):
//    - state=INIT, sweep counter=1, all busy bits=0, ready_o=0.
//    - Storage array is not reset; the sweep clears it.
//  - INIT:
//    - Each clock edge writes 0 to reg[counter], then counter++.
//    - The edge that writes NREGS-1 moves to RUN; ready_o=1 from that edge (registered).
//    - The sweep takes NREGS-1 edges. stall_i does not pause it.
//    - In INIT: we_i, rsv_i and flush_i are ignored; rdata_o=0; rbusy_o=0.
//  - Register 0 is hardwired:
//    - Reads return 0; it is never busy.
//    - Writes and reserves to address 0 are dropped.
//  - Commit:
//    - Write port k commits iff state=RUN, stall_i=0, we_i[k]=1 and waddr!=0.
//    - A commit updates reg[waddr] on the clock edge.
//    - Several ports targeting the same address: the highest k wins. No error.
//  - Read (RUN):
//    - BYPASS=1: if any committing port matches raddr_j (nonzero), rdata_j = wdata of the highest matching k.
//    - Otherwise rdata_j = reg[raddr_j]. Zero read latency.
//  - Scoreboard (RUN, stall_i=0), applied in this order on one edge:
//    1. flush_i=1 clears all busy bits.
//    2. Each committing write clears busy[waddr].
//    3. rsv_i=1 and rsv_addr_i!=0 sets busy[rsv_addr_i].
//       A reserve wins over a same-cycle write or flush to the same register.
//  - rbusy_o[j] = busy[raddr_j]. With BYPASS=1 it is forced to 0 when a committing write matches raddr_j.
//    That write takes effect only if no same-cycle reserve hits the same address.
//  - stall_i=1 in RUN: storage and busy bits hold; no bypass. Reads show stored value and stored busy bit.
//  - Reset mid-RUN or mid-INIT: aborts immediately.
//    - ready_o drops asynchronously; busy bits clear.
//    - A full sweep restarts after release; old contents are discarded.
// TESTING
//  1. Reset, release -> ready_o=0 for 31 edges, 1 after edge 31; every raddr reads 0.
//  2. RUN: we_i[0]=1, waddr=5, wdata=0xDEADBEEF, raddr0=5 same cycle
//     -> BYPASS=1: rdata0=0xDEADBEEF in that cycle; BYPASS=0: old value, new value next cycle.
//  3. NWR=2, both ports write reg 7 (0x11, 0x22)
//     -> reg 7 = 0x22; a write to reg 0 leaves a reg 0 read at 0.
//  4. rsv_i, addr=9 -> rbusy=1 next cycle; write reg 9 -> rbusy=0.
//     Write and reserve reg 9 same cycle -> stays busy. flush_i with rsv addr 3 -> only reg 3 busy.
//  5. stall_i=1 with we_i=1, addr=4, data=0x55 and rsv_i addr 4
//     -> reg 4 and busy[4] unchanged; no bypass on rdata.
//  6. Assert rst_i mid-RUN and mid-INIT (counter=10)
//     -> ready_o=0 immediately, busy cleared, full 31-edge sweep, prior data reads 0.

Source files
------------

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if
//   Bundles the traffic-side signals of the multi-port register file.
//   The slave modport is used by the register file. The master modport is
//   used by the issue/writeback logic that drives it.
//   Signals (direction as seen by the register file):
//     stall_i     in   block writes, reserves and flushes this cycle
//     ready_o     out  init sweep finished, traffic accepted
//     we_i        in   [NWR]       write enable per write port
//     waddr_i     in   [NWR*AW]    write address, port k at [k*AW +: AW]
//     wdata_i     in   [NWR*XLEN]  write data, port k at [k*XLEN +: XLEN]
//     raddr_i     in   [NRD*AW]    read address, port j at [j*AW +: AW]
//     rdata_o     out  [NRD*XLEN]  combinational read data
//     rbusy_o     out  [NRD]       pending producer on the read register
//     rsv_i       in   reserve request
//     rsv_addr_i  in   [AW]        register to reserve
//     flush_i     in   clear all busy bits
interface regfile_mp_sb_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1
);
   localparam int AW = $clog2(NREGS);

   logic                 stall_i;
   logic                 ready_o;
   logic [NWR-1:0]       we_i;
   logic [NWR*AW-1:0]    waddr_i;
   logic [NWR*XLEN-1:0]  wdata_i;
   logic [NRD*AW-1:0]    raddr_i;
   logic [NRD*XLEN-1:0]  rdata_o;
   logic [NRD-1:0]       rbusy_o;
   logic                 rsv_i;
   logic [AW-1:0]        rsv_addr_i;
   logic                 flush_i;

   modport slave (
      input  stall_i, we_i, waddr_i, wdata_i, raddr_i, rsv_i, rsv_addr_i, flush_i,
      output ready_o, rdata_o, rbusy_o
   );

   modport master (
      output stall_i, we_i, waddr_i, wdata_i, raddr_i, rsv_i, rsv_addr_i, flush_i,
      input  ready_o, rdata_o, rbusy_o
   );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
//   Multi-port integer register file with a per-register busy scoreboard.
//   After reset it runs a zero-init sweep over registers 1..NREGS-1 and then
//   accepts traffic. Register 0 always reads as zero and is never busy.
//   Ports:
//     clk_i  in  clock, all state on the rising edge
//     rst_i  in  asynchronous active-high reset
//     bus    regfile_mp_sb_if.slave (write/read/scoreboard traffic)
module regfile_mp_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1
) (
   input  logic           clk_i,
   input  logic           rst_i,
   regfile_mp_sb_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          cnt_q;
   logic [NREGS-1:0]       busy_q, busy_d;
   logic [XLEN-1:0]        mem_q [NREGS];
   logic                   run, upd;
   logic [NWR-1:0]         commit;
   logic [NRD*XLEN-1:0]    rdata_c;
   logic [NRD-1:0]         rbusy_c;
   logic [AW-1:0]          ra;
   logic                   rsv_hit;

   assign run         = (state_q == S_RUN);
   // Stall freezes every state update in RUN; the sweep ignores it.
   assign upd         = run && !bus.stall_i;
   assign bus.ready_o = run;

   // Control state: FSM, sweep counter, scoreboard
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_INIT;
         cnt_q   <= AW'(1);
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_INIT) cnt_q <= cnt_q + AW'(1);
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == S_INIT && cnt_q == AW'(NREGS - 1)) state_d = S_RUN;
   end

   always_comb begin
      for (int k = 0; k < NWR; k++)
         commit[k] = upd && bus.we_i[k] && (bus.waddr_i[k*AW +: AW] != '0);
   end

   // Flush, then write-clears, then reserve: a reserve overrides both.
   always_comb begin
      busy_d = busy_q;
      if (upd) begin
         if (bus.flush_i) busy_d = '0;
         for (int k = 0; k < NWR; k++)
            if (commit[k]) busy_d[bus.waddr_i[k*AW +: AW]] = 1'b0;
         if (bus.rsv_i && bus.rsv_addr_i != '0) busy_d[bus.rsv_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Storage: no reset; the sweep clears it. Later ports overwrite earlier ones.
   always_ff @(posedge clk_i) begin
      if (state_q == S_INIT) begin
         mem_q[cnt_q] <= '0;
      end else begin
         for (int k = 0; k < NWR; k++)
            if (commit[k]) mem_q[bus.waddr_i[k*AW +: AW]] <= bus.wdata_i[k*XLEN +: XLEN];
      end
   end

   // Read ports: combinational, highest matching committing port forwarded.
   always_comb begin
      rdata_c = '0;
      rbusy_c = '0;
      ra      = '0;
      rsv_hit = 1'b0;
      for (int j = 0; j < NRD; j++) begin
         ra      = bus.raddr_i[j*AW +: AW];
         rsv_hit = upd && bus.rsv_i && (bus.rsv_addr_i == ra);
         if (run && ra != '0) begin
            rdata_c[j*XLEN +: XLEN] = mem_q[ra];
            rbusy_c[j]              = busy_q[ra];
            if (BYPASS != 0) begin
               for (int k = 0; k < NWR; k++) begin
                  if (commit[k] && bus.waddr_i[k*AW +: AW] == ra) begin
                     rdata_c[j*XLEN +: XLEN] = bus.wdata_i[k*XLEN +: XLEN];
                     // A same-cycle reserve keeps the register pending.
                     if (!rsv_hit) rbusy_c[j] = 1'b0;
                  end
               end
            end
         end
      end
   end

   assign bus.rdata_o = rdata_c;
   assign bus.rbusy_o = rbusy_c;
endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk_i = ~clk_i;

   // bif drives the bypassing DUT; nif mirrors its inputs into a BYPASS=0 copy.
   regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bif ();
   regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) nif ();

   assign nif.stall_i    = bif.stall_i;
   assign nif.we_i       = bif.we_i;
   assign nif.waddr_i    = bif.waddr_i;
   assign nif.wdata_i    = bif.wdata_i;
   assign nif.raddr_i    = bif.raddr_i;
   assign nif.rsv_i      = bif.rsv_i;
   assign nif.rsv_addr_i = bif.rsv_addr_i;
   assign nif.flush_i    = bif.flush_i;

   regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bif)
   );

   regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (nif)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bif.stall_i    = 1'b0;
      bif.we_i       = '0;
      bif.waddr_i    = '0;
      bif.wdata_i    = '0;
      bif.raddr_i    = '0;
      bif.rsv_i      = 1'b0;
      bif.rsv_addr_i = '0;
      bif.flush_i    = 1'b0;
   endtask

   // Counts rising edges after reset release until ready_o rises (bounded).
   task automatic wait_sweep(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk_i);
         #1;
         n++;
      end while (!bif.ready_o && n < 100);
      chk(tag, 64'(n), 64'd31);
      chk({tag, "_nb_ready"}, 64'(nif.ready_o), 64'd1);
   endtask

   initial begin
      int bad;
      idle();
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_ready", 64'(bif.ready_o), 64'd0);
      chk("rst_rbusy", 64'(bif.rbusy_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      bif.raddr_i = {5'd6, 5'd5};
      #1;
      chk("init_rdata", 64'(bif.rdata_o), 64'd0);
      wait_sweep("sweep1");

      // Every register reads zero after the sweep
      bad = 0;
      for (int r = 0; r < 32; r++) begin
         bif.raddr_i = {5'(31 - r), 5'(r)};
         #1;
         if (bif.rdata_o !== 64'd0 || nif.rdata_o !== 64'd0) bad++;
      end
      chk("sweep_zero", 64'(bad), 64'd0);

      // Bypass vs stored read on the same-cycle write
      @(negedge clk_i);
      idle();
      bif.we_i = 2'b01; bif.waddr_i = {5'd0, 5'd5};
      bif.wdata_i = {32'h0, 32'hDEADBEEF}; bif.raddr_i = {5'd0, 5'd5};
      #1;
      chk("byp_same", 64'(bif.rdata_o[31:0]), 64'hDEADBEEF);
      chk("nobyp_same", 64'(nif.rdata_o[31:0]), 64'h0);
      @(posedge clk_i);
      #1;
      chk("nobyp_next", 64'(nif.rdata_o[31:0]), 64'hDEADBEEF);

      // Two ports to reg 7: highest port wins
      @(negedge clk_i);
      idle();
      bif.we_i = 2'b11; bif.waddr_i = {5'd7, 5'd7};
      bif.wdata_i = {32'h22, 32'h11}; bif.raddr_i = {5'd0, 5'd7};
      #1;
      chk("byp_multi", 64'(bif.rdata_o[31:0]), 64'h22);
      @(negedge clk_i);
      idle();
      bif.raddr_i = {5'd7, 5'd5};
      #1;
      chk("multi_reg7", 64'(bif.rdata_o[63:32]), 64'h22);
      chk("multi_reg7_nb", 64'(nif.rdata_o[63:32]), 64'h22);
      chk("reg5_kept", 64'(bif.rdata_o[31:0]), 64'hDEADBEEF);

      // Writes to reg 0 are dropped
      @(negedge clk_i);
      bif.we_i = 2'b01; bif.waddr_i = '0; bif.wdata_i = {32'h0, 32'hFFFF}; bif.raddr_i = '0;
      #1;
      chk("r0_byp", 64'(bif.rdata_o[31:0]), 64'h0);
      @(negedge clk_i);
      idle();
      #1;
      chk("r0_after", 64'(nif.rdata_o[31:0]), 64'h0);

      // Scoreboard: reserve, clear by write, write+reserve, flush+reserve
      @(negedge clk_i);
      bif.rsv_i = 1'b1; bif.rsv_addr_i = 5'd9; bif.raddr_i = {5'd9, 5'd0};
      #1;
      chk("rsv_before", 64'(bif.rbusy_o[1]), 64'd0);
      @(negedge clk_i);
      bif.rsv_i = 1'b0;
      #1;
      chk("rsv_busy", 64'(bif.rbusy_o[1]), 64'd1);
      @(negedge clk_i);
      bif.we_i = 2'b01; bif.waddr_i = {5'd0, 5'd9}; bif.wdata_i = {32'h0, 32'h99};
      #1;
      chk("wr_force0", 64'(bif.rbusy_o[1]), 64'd0);
      chk("wr_nb_busy", 64'(nif.rbusy_o[1]), 64'd1);
      @(negedge clk_i);
      bif.we_i = 2'b00;
      #1;
      chk("wr_clear", 64'(bif.rbusy_o[1]), 64'd0);
      @(negedge clk_i);
      bif.we_i = 2'b01; bif.wdata_i = {32'h0, 32'h99};
      bif.rsv_i = 1'b1; bif.rsv_addr_i = 5'd9;
      @(negedge clk_i);
      idle();
      bif.raddr_i = {5'd9, 5'd0};
      #1;
      chk("wr_rsv_busy", 64'(bif.rbusy_o[1]), 64'd1);
      bif.rsv_i = 1'b1; bif.rsv_addr_i = 5'd12;
      @(negedge clk_i);
      bif.flush_i = 1'b1; bif.rsv_addr_i = 5'd3;
      @(negedge clk_i);
      idle();
      bif.raddr_i = {5'd9, 5'd3};
      #1;
      chk("flush_r3", 64'(bif.rbusy_o[0]), 64'd1);
      chk("flush_r9", 64'(bif.rbusy_o[1]), 64'd0);
      bif.raddr_i = {5'd12, 5'd3};
      #1;
      chk("flush_r12", 64'(bif.rbusy_o[1]), 64'd0);

      // Stall blocks write, reserve and bypass
      @(negedge clk_i);
      bif.stall_i = 1'b1; bif.we_i = 2'b01; bif.waddr_i = {5'd0, 5'd4};
      bif.wdata_i = {32'h0, 32'h55}; bif.rsv_i = 1'b1; bif.rsv_addr_i = 5'd4;
      bif.raddr_i = {5'd0, 5'd4};
      #1;
      chk("stall_nobyp", 64'(bif.rdata_o[31:0]), 64'h0);
      @(negedge clk_i);
      idle();
      bif.raddr_i = {5'd0, 5'd4};
      #1;
      chk("stall_data", 64'(bif.rdata_o[31:0]), 64'h0);
      chk("stall_busy", 64'(bif.rbusy_o[0]), 64'd0);

      // Reset mid-RUN: async drop, full re-sweep, old data and busy gone
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      chk("midrun_ready", 64'(bif.ready_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      wait_sweep("sweep_run");
      bif.raddr_i = {5'd9, 5'd7};
      #1;
      chk("midrun_data", 64'(bif.rdata_o), 64'h0);
      bif.raddr_i = {5'd5, 5'd3};
      #1;
      chk("midrun_busy3", 64'(bif.rbusy_o[0]), 64'd0);
      chk("midrun_r5", 64'(nif.rdata_o[63:32]), 64'h0);

      // Reset mid-INIT (counter at 10): sweep restarts from the beginning
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (9) @(posedge clk_i);
      #1;
      chk("midinit_ready", 64'(bif.ready_o), 64'd0);
      #2;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      wait_sweep("sweep_init");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
